// File: rtl/jtag_master.sv
// Host-side JTAG initiator: runs IR/DR scans, TAP resets and idle clocking
// from a valid/ready command channel and returns captured TDO bits.
module jtag_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32,
    parameter int LENW    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LENW-1:0]    cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    localparam int CNTW = $clog2(2 * CLK_DIV);
    localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNTW-1:0] CNT_RISE = CNTW'(CLK_DIV - 1);
    localparam logic [CNTW-1:0] CNT_END  = CNTW'(2 * CLK_DIV - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);
    localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAX_LEN);
    localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
    localparam logic [LENW-1:0] LEN_ZERO = LENW'(0);
    localparam logic [LENW-1:0] RST_LAST = LENW'(5);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_RESET = 3'd1,
        ST_HEAD      = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_TAIL      = 3'd4,
        ST_RESP      = 3'd5
    } state_e;

    state_e             state_r, state_s;
    logic [LENW-1:0]    idx_r, idx_s;
    logic [CNTW-1:0]    cnt_r, cnt_s;
    logic [1:0]         op_r, op_s;
    logic [LENW-1:0]    len_r, len_s;
    logic [MAX_LEN-1:0] data_r, data_s;
    logic               tap_known_r, tap_known_s;
    logic [MAX_LEN-1:0] rsp_data_r, rsp_data_s;
    logic               rsp_valid_r, rsp_valid_s;
    logic               busy_r, busy_s;
    logic               cmd_ready_r, cmd_ready_s;
    logic               tck_r, tck_s;
    logic               tms_r, tms_s;
    logic               tdi_r, tdi_s;

    state_e             seq_state_s;
    logic [LENW-1:0]    seq_idx_s;
    logic               seq_known_s;
    state_e             first_state_s;
    logic [LENW-1:0]    cmd_len_eff_s;

    function automatic logic [LENW-1:0] head_last(input logic [1:0] op);
        case (op)
            OP_RESET: head_last = RST_LAST;
            OP_IR:    head_last = LENW'(3);
            default:  head_last = LENW'(2);
        endcase
    endfunction

    function automatic logic pulse_tms(input state_e st, input logic [LENW-1:0] idx,
                                       input logic [1:0] op, input logic [LENW-1:0] len);
        case (st)
            ST_PRE_RESET: pulse_tms = (idx != RST_LAST);
            ST_HEAD: begin
                case (op)
                    OP_RESET: pulse_tms = (idx != RST_LAST);
                    OP_IR:    pulse_tms = (idx < LENW'(2));
                    OP_DR:    pulse_tms = (idx == LEN_ZERO);
                    default:  pulse_tms = 1'b0;
                endcase
            end
            ST_SHIFT: pulse_tms = (op != OP_IDLE) && (idx == len - LEN_ONE);
            ST_TAIL:  pulse_tms = (idx == LEN_ZERO);
            default:  pulse_tms = 1'b0;
        endcase
    endfunction

    function automatic logic pulse_tdi(input state_e st, input logic [LENW-1:0] idx,
                                       input logic [1:0] op, input logic [MAX_LEN-1:0] data);
        pulse_tdi = ((st == ST_SHIFT) && (op != OP_IDLE)) ? data[IDXW'(idx)] : 1'b0;
    endfunction

    // Which pulse follows the one currently in flight, and whether the TAP becomes known
    always_comb begin
        seq_state_s = state_r;
        seq_idx_s   = idx_r + LEN_ONE;
        seq_known_s = tap_known_r;
        case (state_r)
            ST_PRE_RESET: begin
                if (idx_r == RST_LAST) begin
                    seq_idx_s   = LEN_ZERO;
                    seq_known_s = 1'b1;
                    seq_state_s = (op_r == OP_IDLE) ? ST_SHIFT : ST_HEAD;
                end else begin
                    seq_state_s = ST_PRE_RESET;
                end
            end
            ST_HEAD: begin
                if (idx_r == head_last(op_r)) begin
                    seq_idx_s = LEN_ZERO;
                    if (op_r == OP_RESET) begin
                        seq_state_s = ST_RESP;
                        seq_known_s = 1'b1;
                    end else begin
                        seq_state_s = ST_SHIFT;
                    end
                end else begin
                    seq_state_s = ST_HEAD;
                end
            end
            ST_SHIFT: begin
                if (idx_r == len_r - LEN_ONE) begin
                    seq_idx_s   = LEN_ZERO;
                    seq_state_s = (op_r == OP_IDLE) ? ST_RESP : ST_TAIL;
                end else begin
                    seq_state_s = ST_SHIFT;
                end
            end
            ST_TAIL: begin
                if (idx_r == LEN_ONE) begin
                    seq_idx_s   = LEN_ZERO;
                    seq_state_s = ST_RESP;
                end else begin
                    seq_state_s = ST_TAIL;
                end
            end
            default: begin
                seq_idx_s   = LEN_ZERO;
                seq_state_s = ST_IDLE;
            end
        endcase
    end

    // Command acceptance, TCK divider, TDO capture and response handshake
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        cnt_s       = cnt_r;
        op_s        = op_r;
        len_s       = len_r;
        data_s      = data_r;
        tap_known_s = tap_known_r;
        rsp_data_s  = rsp_data_r;
        tck_s       = tck_r;
        tms_s       = tms_r;
        tdi_s       = tdi_r;

        cmd_len_eff_s = ((cmd_len == LEN_ZERO) || (cmd_len > LEN_MAX)) ? LEN_MAX : cmd_len;
        if (!tap_known_r && (cmd_op != OP_RESET)) begin
            first_state_s = ST_PRE_RESET;
        end else if (cmd_op == OP_IDLE) begin
            first_state_s = ST_SHIFT;
        end else begin
            first_state_s = ST_HEAD;
        end

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    op_s       = cmd_op;
                    len_s      = cmd_len_eff_s;
                    data_s     = cmd_data;
                    rsp_data_s = {MAX_LEN{1'b0}};
                    state_s    = first_state_s;
                    idx_s      = LEN_ZERO;
                    cnt_s      = CNT_ZERO;
                    tck_s      = 1'b0;
                    tms_s      = pulse_tms(first_state_s, LEN_ZERO, cmd_op, cmd_len_eff_s);
                    tdi_s      = pulse_tdi(first_state_s, LEN_ZERO, cmd_op, cmd_data);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE_RESET, ST_HEAD, ST_SHIFT, ST_TAIL: begin
                cnt_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_RISE) begin
                    tck_s = 1'b1;
                    if ((state_r == ST_SHIFT) && (op_r != OP_IDLE)) begin
                        rsp_data_s[IDXW'(idx_r)] = jtag_tdo;
                    end else begin
                        rsp_data_s = rsp_data_r;
                    end
                end else if (cnt_r == CNT_END) begin
                    tck_s       = 1'b0;
                    cnt_s       = CNT_ZERO;
                    state_s     = seq_state_s;
                    idx_s       = seq_idx_s;
                    tap_known_s = seq_known_s;
                    // The last pulse's TMS is held so the TAP stays parked where it landed
                    if (seq_state_s != ST_RESP) begin
                        tms_s = pulse_tms(seq_state_s, seq_idx_s, op_r, len_r);
                        tdi_s = pulse_tdi(seq_state_s, seq_idx_s, op_r, data_r);
                    end else begin
                        tms_s = tms_r;
                        tdi_s = 1'b0;
                    end
                end else begin
                    tck_s = tck_r;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s      = (state_s == ST_PRE_RESET) || (state_s == ST_HEAD) ||
                      (state_s == ST_SHIFT) || (state_s == ST_TAIL);
        rsp_valid_s = (state_s == ST_RESP);
        cmd_ready_s = (state_s == ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= LEN_ZERO;
            cnt_r       <= CNT_ZERO;
            op_r        <= 2'b00;
            len_r       <= LEN_ZERO;
            data_r      <= {MAX_LEN{1'b0}};
            tap_known_r <= 1'b0;
            rsp_data_r  <= {MAX_LEN{1'b0}};
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
            tck_r       <= 1'b0;
            tms_r       <= 1'b1;
            tdi_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            op_r        <= op_s;
            len_r       <= len_s;
            data_r      <= data_s;
            tap_known_r <= tap_known_s;
            rsp_data_r  <= rsp_data_s;
            rsp_valid_r <= rsp_valid_s;
            busy_r      <= busy_s;
            cmd_ready_r <= cmd_ready_s;
            tck_r       <= tck_s;
            tms_r       <= tms_s;
            tdi_r       <= tdi_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;
    assign jtag_tck  = tck_r;
    assign jtag_tms  = tms_r;
    assign jtag_tdi  = tdi_r;

endmodule
